// File: rtl/bitblaster_pkg.sv
// Shared encodings for the bitblaster datapath: ALU function codes, opcodes, timesteps, widths.
package bitblaster_pkg;

  localparam int unsigned NREG  = 4;
  localparam int unsigned BUS_W = 10;
  localparam int unsigned IMMW  = 6;
  localparam int unsigned FN_W  = 4;

  // ALU function codes, shared with the ALU
  localparam logic [FN_W-1:0] FN_LOAD = 4'b0000;
  localparam logic [FN_W-1:0] FN_COPY = 4'b0001;
  localparam logic [FN_W-1:0] FN_ADD  = 4'b0010;
  localparam logic [FN_W-1:0] FN_SUB  = 4'b0011;
  localparam logic [FN_W-1:0] FN_INV  = 4'b0100;
  localparam logic [FN_W-1:0] FN_FLP  = 4'b0101;
  localparam logic [FN_W-1:0] FN_AND  = 4'b0110;
  localparam logic [FN_W-1:0] FN_OR   = 4'b0111;
  localparam logic [FN_W-1:0] FN_XOR  = 4'b1000;
  localparam logic [FN_W-1:0] FN_LSL  = 4'b1001;
  localparam logic [FN_W-1:0] FN_LSR  = 4'b1010;
  localparam logic [FN_W-1:0] FN_ASR  = 4'b1011;
  localparam logic [FN_W-1:0] FN_ADDI = 4'b1100;
  localparam logic [FN_W-1:0] FN_SUBI = 4'b1101;

  // Opcode field IR[9:8]
  localparam logic [1:0] OP_RR   = 2'b00;
  localparam logic [1:0] OP_RSV  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_SUBI = 2'b11;

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;

  // Instruction classes sharing one timestep sequence
  typedef enum logic [2:0] {CLS_NOP, CLS_LD, CLS_CP, CLS_UN, CLS_BIN, CLS_IMM} cls_e;

  // Map an instruction word onto its sequence class
  function automatic cls_e decode_cls(input logic [BUS_W-1:0] ir);
    cls_e c;
    c = CLS_NOP;
    unique case (ir[9:8])
      OP_RR: begin
        case (ir[3:0])
          FN_LOAD:                         c = CLS_LD;
          FN_COPY:                         c = CLS_CP;
          FN_INV, FN_FLP:                  c = CLS_UN;
          FN_ADD, FN_SUB, FN_AND, FN_OR,
          FN_XOR, FN_LSL, FN_LSR, FN_ASR:  c = CLS_BIN;
          default:                         c = CLS_NOP;
        endcase
      end
      OP_RSV:           c = CLS_NOP;
      OP_ADDI, OP_SUBI: c = CLS_IMM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_controller_dec2to4.sv
// 2-bit register index to one-hot enable decoder; all zero when disabled.
module dec2to4
  import bitblaster_pkg::*;
(
  input  logic [1:0]      sel_i,
  input  logic            en_i,
  output logic [NREG-1:0] y_o
);

  // One-hot decode gated by enable
  always_comb begin
    y_o = '0;
    if (en_i) y_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/alu_controller.sv
// Instruction sequencer: latches INST on an Exec rise and walks T0..T3 driving bus/ALU controls.
module alu_controller
  import bitblaster_pkg::*;
(
  input  logic             CLKb,
  input  logic             Clear,
  input  logic [BUS_W-1:0] INST,
  input  logic             Exec,
  output logic             IRin,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic             ExtOut,
  output logic             IMMout,
  output logic [BUS_W-1:0] IMM,
  output logic             Ain,
  output logic             Gin,
  output logic             Gout,
  output logic [FN_W-1:0]  ALUcont,
  output logic             Done,
  output logic             Busy
);

  tstep_e           state_q, state_d;
  logic [BUS_W-1:0] ir_q, ir_d;
  logic             exec_q;
  logic             start_c;
  cls_e             cls_c;
  logic [1:0]       x_c, y_c;
  logic             rin_en, rout_en;
  logic [1:0]       rin_sel, rout_sel;

  assign start_c = (state_q == T0) && Exec && !exec_q;
  assign cls_c   = decode_cls(ir_q);
  assign x_c     = ir_q[7:6];
  assign y_c     = ir_q[5:4];
  assign IMM     = BUS_W'(ir_q[IMMW-1:0]);
  assign Busy    = (state_q != T0);

  // State, instruction register and Exec history; Clear abandons any instruction in flight
  always_ff @(negedge CLKb) begin
    if (Clear) begin
      state_q <= T0;
      ir_q    <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      exec_q  <= Exec;
    end
  end

  // Next timestep and per-timestep control decode
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    IRin     = 1'b0;
    rin_en   = 1'b0;
    rin_sel  = x_c;
    rout_en  = 1'b0;
    rout_sel = x_c;
    ExtOut   = 1'b0;
    IMMout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    ALUcont  = '0;
    Done     = 1'b0;
    unique case (state_q)
      T0: begin
        if (start_c) begin
          IRin    = 1'b1;
          ir_d    = INST;
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        unique case (cls_c)
          CLS_LD: begin
            ExtOut = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          CLS_CP: begin
            rout_en  = 1'b1;
            rout_sel = y_c;
            rin_en   = 1'b1;
            Done     = 1'b1;
          end
          CLS_UN: begin
            rout_en  = 1'b1;
            rout_sel = y_c;
            Ain      = 1'b1;
            state_d  = T2;
          end
          CLS_BIN, CLS_IMM: begin
            rout_en = 1'b1;
            Ain     = 1'b1;
            state_d = T2;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        state_d = T3;
        Gin     = 1'b1;
        if (cls_c == CLS_IMM) begin
          IMMout  = 1'b1;
          ALUcont = (ir_q[9:8] == OP_ADDI) ? FN_ADDI : FN_SUBI;
        end else begin
          ALUcont = ir_q[3:0];
          if (cls_c == CLS_BIN) begin
            rout_en  = 1'b1;
            rout_sel = y_c;
          end
        end
      end
      T3: begin
        state_d = T0;
        Gout    = 1'b1;
        rin_en  = 1'b1;
        Done    = 1'b1;
      end
    endcase
  end

  dec2to4 u_rin_dec (
    .sel_i (rin_sel),
    .en_i  (rin_en),
    .y_o   (Rin)
  );

  dec2to4 u_rout_dec (
    .sel_i (rout_sel),
    .en_i  (rout_en),
    .y_o   (Rout)
  );

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller: fixed instruction vectors with hand-computed control words.
module tb_alu_controller;

  logic       CLKb;
  logic       Clear;
  logic [9:0] INST;
  logic       Exec;
  logic       IRin;
  logic [3:0] Rin;
  logic [3:0] Rout;
  logic       ExtOut;
  logic       IMMout;
  logic [9:0] IMM;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] ALUcont;
  logic       Done;
  logic       Busy;

  int tests = 0;
  int fails = 0;
  int done_cnt;

  alu_controller dut (
    .CLKb    (CLKb),
    .Clear   (Clear),
    .INST    (INST),
    .Exec    (Exec),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .ExtOut  (ExtOut),
    .IMMout  (IMMout),
    .IMM     (IMM),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .ALUcont (ALUcont),
    .Done    (Done),
    .Busy    (Busy)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  // Packed observed control word: {IRin,Rin,Rout,ExtOut,IMMout,Ain,Gin,Gout,ALUcont,Done,Busy}
  logic [19:0] obs_ctl;
  assign obs_ctl = {IRin, Rin, Rout, ExtOut, IMMout, Ain, Gin, Gout, ALUcont, Done, Busy};

  function automatic logic [19:0] ctl(input logic irin, input logic [3:0] rin, input logic [3:0] rout,
                                      input logic ext, input logic immo, input logic ain, input logic gin,
                                      input logic gout, input logic [3:0] alu, input logic done,
                                      input logic busy);
    return {irin, rin, rout, ext, immo, ain, gin, gout, alu, done, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active (falling) edge and check the one-driver rule
  task automatic tick();
    int drivers;
    @(negedge CLKb);
    #2;
    drivers = int'(Rout[0]) + int'(Rout[1]) + int'(Rout[2]) + int'(Rout[3])
            + int'(ExtOut) + int'(IMMout) + int'(Gout);
    chk("bus_one_driver", 32'(drivers <= 1), 32'd1);
    if (Done) done_cnt++;
  endtask

  initial begin
    Clear = 1'b1;
    Exec  = 1'b0;
    INST  = '0;
    done_cnt = 0;
    tick();
    tick();
    Clear = 1'b0;
    tick();
    chk("reset_ctl", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));
    chk("reset_imm", 32'(IMM), 32'd0);

    // ld R1
    INST = 10'b00_01_00_0000;
    Exec = 1'b1;
    #1;
    chk("ld_irin", 32'(obs_ctl), 32'(ctl(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));
    tick();
    Exec = 1'b0;
    chk("ld_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1)));
    tick();
    chk("ld_idle", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));

    // add R2,R1
    INST = 10'b00_10_01_0010;
    Exec = 1'b1;
    #1;
    chk("add_irin", 32'(IRin), 32'd1);
    tick();
    Exec = 1'b0;
    chk("add_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 0, 4'b0000, 0, 1)));
    tick();
    chk("add_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0010, 0, 0, 0, 1, 0, 4'b0010, 0, 1)));
    tick();
    chk("add_t3", 32'(obs_ctl), 32'(ctl(0, 4'b0100, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 1)));
    tick();
    chk("add_idle", 32'(Busy), 32'd0);

    // addi R3,42
    INST = 10'b10_11_101010;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    chk("addi_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b1000, 0, 0, 1, 0, 0, 4'b0000, 0, 1)));
    tick();
    chk("addi_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 1, 0, 1, 0, 4'b1100, 0, 1)));
    chk("addi_imm", 32'(IMM), 32'd42);
    tick();
    chk("addi_t3", 32'(obs_ctl), 32'(ctl(0, 4'b1000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 1)));
    tick();

    // subi R0,5
    INST = 10'b11_00_000101;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    tick();
    chk("subi_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 1, 0, 1, 0, 4'b1101, 0, 1)));
    tick();
    chk("subi_t3", 32'(obs_ctl), 32'(ctl(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 1)));
    tick();

    // inv R0,R2: operand from Y, no second read in T2
    INST = 10'b00_00_10_0100;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    chk("inv_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 0, 4'b0000, 0, 1)));
    tick();
    chk("inv_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 4'b0100, 0, 1)));
    tick();
    chk("inv_t3", 32'(obs_ctl), 32'(ctl(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 1)));
    tick();

    // cp R3,R0
    INST = 10'b00_11_00_0001;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    chk("cp_t1", 32'(obs_ctl), 32'(ctl(0, 4'b1000, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 1, 1)));
    tick();

    // sub R0,R3 with Exec held high and a second rise in T2: exactly one Done
    INST = 10'b00_00_11_0011;
    Exec = 1'b1;
    done_cnt = 0;
    tick();
    Exec = 1'b0;
    tick();
    chk("hold_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b1000, 0, 0, 0, 1, 0, 4'b0011, 0, 1)));
    Exec = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_done_count", 32'(done_cnt), 32'd1);
    chk("hold_idle", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));
    Exec = 1'b0;
    tick();

    // sub R1,R2 abandoned by Clear in T2
    INST = 10'b00_01_10_0011;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    tick();
    chk("clr_pre_t2", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0100, 0, 0, 0, 1, 0, 4'b0011, 0, 1)));
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_after", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));
    chk("clr_imm", 32'(IMM), 32'd0);
    tick();
    chk("clr_no_t3", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));

    // ld R2 runs normally after the abandoned instruction
    INST = 10'b00_10_00_0000;
    Exec = 1'b1;
    #1;
    chk("post_clr_irin", 32'(IRin), 32'd1);
    tick();
    Exec = 1'b0;
    chk("post_clr_ld", 32'(obs_ctl), 32'(ctl(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1)));
    tick();

    // Reserved opcode: NOP
    INST = 10'b01_00_000000;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    chk("nop_rsv_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1)));
    tick();
    chk("nop_rsv_idle", 32'(Busy), 32'd0);

    // Register-register FN 1111: NOP
    INST = 10'b00_00_00_1111;
    Exec = 1'b1;
    tick();
    Exec = 1'b0;
    chk("nop_fn_t1", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1)));
    tick();
    chk("nop_fn_idle", 32'(obs_ctl), 32'(ctl(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
